// File: rtl/level_sample_scheduler.sv
// level_sample_scheduler: once per 1 Hz tick, powers the level sensor, waits
// a settle time, collects 2^AVG_LOG2 handshaked samples with per-sample ms
// timeouts, and publishes their truncated mean.
module level_sample_scheduler #(
  parameter int DATA_W     = 12,
  parameter int SETTLE_MS  = 10,
  parameter int TIMEOUT_MS = 50,
  parameter int AVG_LOG2   = 2
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              tick_1kHz,
  input  logic              tick_1Hz,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sensor_en,
  output logic              meas_start,
  output logic              busy,
  output logic [DATA_W-1:0] level_out,
  output logic              level_valid,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int MS_MAX = (SETTLE_MS > TIMEOUT_MS) ? SETTLE_MS : TIMEOUT_MS;
  localparam int MS_W   = (MS_MAX < 1) ? 1 : $clog2(MS_MAX + 1);
  localparam int CNT_W  = AVG_LOG2 + 1;

  localparam logic [MS_W-1:0]  SETTLE_LAST  = MS_W'((SETTLE_MS > 0) ? SETTLE_MS - 1 : 0);
  localparam logic [MS_W-1:0]  TIMEOUT_LAST = MS_W'((TIMEOUT_MS > 0) ? TIMEOUT_MS - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(NSAMP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POWER,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic                terr_q, terr_d;
  logic                ovr_q, ovr_d;
  logic [ACC_W-1:0]    acc_sum;

  // Truncating mean: the accumulator is wide enough that the shifted sum
  // always fits back into DATA_W bits.
  function automatic logic [DATA_W-1:0] mean_trunc(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    shifted = sum >> AVG_LOG2;
    return shifted[DATA_W-1:0];
  endfunction

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      level_q <= '0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      level_q <= level_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Burst sequencing, accumulation, timeout and flag updates.
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    level_d = level_q;
    terr_d  = terr_q;
    ovr_d   = ovr_q;
    acc_sum = acc_q + ACC_W'(sample_data);

    unique case (state_q)
      S_IDLE: begin
        if (tick_1Hz && enable) begin
          state_d = S_POWER;
          acc_d   = '0;
          cnt_d   = '0;
          ms_d    = '0;
        end
      end
      S_POWER: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (SETTLE_MS == 0) begin
          state_d = S_START;
        end else if (tick_1kHz) begin
          if (ms_q == SETTLE_LAST) state_d = S_START;
          else                     ms_d    = ms_q + 1'b1;
        end
      end
      S_START: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          ms_d    = '0;
        end
      end
      S_WAIT: begin
        // A sample arriving with the final timeout tick is still accepted.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (sample_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            level_d = mean_trunc(acc_sum);
            terr_d  = 1'b0;
            ovr_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_START;
          end
        end else if (tick_1kHz) begin
          if (ms_q == TIMEOUT_LAST) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A second-tick arriving mid-burst is flagged, never queued.
    if (tick_1Hz && (state_q != S_IDLE)) ovr_d = 1'b1;
  end

  assign sensor_en   = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign meas_start  = (state_q == S_START);
  assign level_valid = (state_q == S_DONE);
  assign level_out   = level_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_level_sample_scheduler.sv
// Directed-plus-random bench for level_sample_scheduler with an abstract
// reference model (expected mean, flag state) held in plain variables.
module tb_level_sample_scheduler;

  localparam int DW      = 12;
  localparam int SETTLE  = 2;
  localparam int TMO     = 3;
  localparam int ALOG    = 2;
  localparam int NS      = 4;

  logic          clk_100MHz = 1'b0;
  logic          reset;
  logic          tick_1kHz;
  logic          tick_1Hz;
  logic          enable;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          sensor_en;
  logic          meas_start;
  logic          busy;
  logic [DW-1:0] level_out;
  logic          level_valid;
  logic          timeout_err;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int ms_cnt = 0;
  int lv_cnt = 0;

  // Reference model state
  int exp_level = 0;
  int exp_terr  = 0;
  int exp_ovr   = 0;
  logic [DW-1:0] smp [NS];

  level_sample_scheduler #(
    .DATA_W(DW), .SETTLE_MS(SETTLE), .TIMEOUT_MS(TMO), .AVG_LOG2(ALOG)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .tick_1kHz   (tick_1kHz),
    .tick_1Hz    (tick_1Hz),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sensor_en   (sensor_en),
    .meas_start  (meas_start),
    .busy        (busy),
    .level_out   (level_out),
    .level_valid (level_valid),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
    if (meas_start === 1'b1) ms_cnt++;
    if (level_valid === 1'b1) lv_cnt++;
  endtask

  task automatic pulse_1hz();
    tick_1Hz = 1'b1;
    step();
    tick_1Hz = 1'b0;
  endtask

  task automatic pulse_1k();
    tick_1kHz = 1'b1;
    step();
    tick_1kHz = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (meas_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (meas_start !== 1'b1) chk(tag, 32'(meas_start), 1);
  endtask

  // Full burst: gap < 0 means random extra wait cycles before each sample.
  task automatic burst(input string tag, input int gap, input int tie_idx, input int ovr_idx);
    int sum = 0;
    int m0 = ms_cnt;
    int l0 = lv_cnt;
    int g;
    pulse_1hz();
    chk({tag, "_busy_up"}, 32'(busy), 1);
    chk({tag, "_sen_up"}, 32'(sensor_en), 1);
    for (int k = 0; k < SETTLE; k++) pulse_1k();
    for (int i = 0; i < NS; i++) begin
      wait_start({tag, "_start"});
      step();
      if (i == ovr_idx) begin
        pulse_1hz();
        exp_ovr = 1;
        chk({tag, "_ovr_set"}, 32'(overrun), 1);
      end
      if (i == tie_idx) begin
        for (int k = 0; k < TMO - 1; k++) pulse_1k();
        tick_1kHz = 1'b1;
      end else begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int k = 0; k < g; k++) step();
      end
      if (i == NS - 1) chk({tag, "_terr_pre"}, 32'(timeout_err), 32'(exp_terr));
      sum += int'(smp[i]);
      sample_valid = 1'b1;
      sample_data  = smp[i];
      step();
      sample_valid = 1'b0;
      tick_1kHz    = 1'b0;
      sample_data  = $urandom_range(0, 4095);
      if (i == tie_idx) chk({tag, "_tie_terr"}, 32'(timeout_err), 0);
      if (i < NS - 1) begin
        chk({tag, "_next_start"}, 32'(meas_start), 1);
      end else begin
        exp_level = sum / NS;
        exp_terr  = 0;
        exp_ovr   = 0;
        chk({tag, "_lv"}, 32'(level_valid), 1);
        chk({tag, "_level"}, 32'(level_out), 32'(exp_level));
        chk({tag, "_terr"}, 32'(timeout_err), 32'(exp_terr));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        step();
        chk({tag, "_lv_width"}, 32'(level_valid), 0);
        chk({tag, "_sen_down"}, 32'(sensor_en), 0);
        chk({tag, "_busy_down"}, 32'(busy), 0);
      end
    end
    for (int k = 0; k < 4; k++) step();
    chk({tag, "_n_start"}, 32'(ms_cnt - m0), NS);
    chk({tag, "_n_lv"}, 32'(lv_cnt - l0), 1);
    chk({tag, "_idle_after"}, 32'(busy), 0);
  endtask

  initial begin
    int m0, l0;
    reset        = 1'b1;
    tick_1kHz    = 1'b0;
    tick_1Hz     = 1'b0;
    enable       = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    step(); step();
    chk("rst_sen", 32'(sensor_en), 0);
    chk("rst_start", 32'(meas_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level_out), 0);
    chk("rst_lv", 32'(level_valid), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    reset = 1'b0;
    step(); step();

    // Basic burst: 100,101,102,105 sampled 3 cycles after each start
    smp[0] = 12'd100; smp[1] = 12'd101; smp[2] = 12'd102; smp[3] = 12'd105;
    burst("basic", 2, -1, -1);

    // Timeout on the second sample
    pulse_1hz();
    for (int k = 0; k < SETTLE; k++) pulse_1k();
    l0 = lv_cnt;
    wait_start("to_start0");
    step();
    sample_valid = 1'b1;
    sample_data  = 12'd7;
    step();
    sample_valid = 1'b0;
    chk("to_start1", 32'(meas_start), 1);
    step();
    pulse_1k();
    pulse_1k();
    chk("to_still_busy", 32'(busy), 1);
    pulse_1k();
    exp_terr = 1;
    chk("to_idle", 32'(busy), 0);
    chk("to_terr", 32'(timeout_err), 32'(exp_terr));
    chk("to_level_hold", 32'(level_out), 32'(exp_level));
    step(); step();
    chk("to_no_lv", 32'(lv_cnt - l0), 0);

    // Good burst after the timeout clears the error
    for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
    burst("recover", -1, -1, -1);

    // Sample coinciding with the timeout-reaching tick
    for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
    burst("tie", -1, 1, -1);

    // Second tick mid-burst
    for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
    burst("overrun", -1, -1, 2);

    // Enable drop while settling
    m0 = ms_cnt;
    pulse_1hz();
    chk("en_busy", 32'(busy), 1);
    enable = 1'b0;
    step();
    chk("en_idle", 32'(busy), 0);
    for (int k = 0; k < 3; k++) pulse_1k();
    chk("en_no_start", 32'(ms_cnt - m0), 0);
    pulse_1hz();
    chk("en_low_1hz", 32'(busy), 0);
    enable = 1'b1;

    // Stray sample while idle
    sample_valid = 1'b1;
    sample_data  = 12'd4095;
    step();
    sample_valid = 1'b0;
    step();
    chk("stray_level", 32'(level_out), 32'(exp_level));
    chk("stray_busy", 32'(busy), 0);
    smp[0] = 12'd8; smp[1] = 12'd9; smp[2] = 12'd10; smp[3] = 12'd13;
    burst("post_stray", -1, -1, -1);

    // Random bursts
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NS; i++) smp[i] = $urandom_range(0, 4095);
      burst("rand", -1, -1, -1);
    end

    // Asynchronous reset in WAIT
    smp[0] = 12'd1000;
    pulse_1hz();
    for (int k = 0; k < SETTLE; k++) pulse_1k();
    wait_start("ar_start");
    step();
    sample_valid = 1'b1;
    sample_data  = smp[0];
    step();
    sample_valid = 1'b0;
    step();
    #3;
    reset = 1'b1;
    #1;
    exp_level = 0; exp_terr = 0; exp_ovr = 0;
    chk("ar_sen", 32'(sensor_en), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_start_o", 32'(meas_start), 0);
    chk("ar_level", 32'(level_out), 32'(exp_level));
    chk("ar_lv", 32'(level_valid), 0);
    chk("ar_terr", 32'(timeout_err), 0);
    chk("ar_ovr", 32'(overrun), 0);
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < NS; i++) smp[i] = 12'd4095;
    burst("ar_fresh", -1, -1, -1);
    chk("ar_fresh_level", 32'(level_out), 4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
